uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//  Parametrised next-generation UART receiver: configurable data width, optional parity, 1 or 2 stop bits.
//  Samples each bit three times around mid-bit and takes the majority vote.
//  Delivers frames through a valid/ready holding register with parity, framing, break and overrun flags.
//  Sits between the RX pin and the system register/FIFO layer, replacing the fixed 8-bit receiver.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame, legal 5..9, LSB first on the line
//  PRESCALE_W  6  width of prescale input; prescale values 8/16/32 are legal
// PORTS
//  UartRxP_CLK         in   1           system clock, rising edge
//  UartRxP_RST         in   1           asynchronous, active-high reset
//  UartRxP_RX_IN       in   1           serial line, idle high, asynchronous to CLK
//  UartRxP_prescale    in   PRESCALE_W  clocks per bit (8,16,32)
//  UartRxP_PAR_EN      in   1           1 = parity bit present after data
//  UartRxP_Par_Type    in   1           0 = even, 1 = odd
//  UartRxP_STOP2       in   1           1 = two stop bits expected
//  UartRxP_Data_Ready  in   1           consumer accepts PDATA when Valid & Ready
//  UartRxP_PDATA       out  DATA_WIDTH  received word
//  UartRxP_Data_Valid  out  1           held word valid until consumed
//  UartRxP_Par_Err     out  1           parity mismatch for held word
//  UartRxP_Frm_Err     out  1           a stop bit sampled 0 for held word
//  UartRxP_Brk         out  1           break: data, parity and stop bits all 0
//  UartRxP_Ovr_Err     out  1           held word overwrote an unconsumed word
//  UartRxP_Busy        out  1           FSM not in IDLE/WAIT_IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM = IDLE; counters 0; 2-flop RX synchroniser resets to 1.
//  RX_IN passes through a 2-flop synchroniser (2-cycle latency); all logic uses the synchronised copy.
//  Config latch: prescale, PAR_EN, Par_Type and STOP2 are latched on start detection; mid-frame changes are ignored.
//    Illegal prescale values are treated as 8.
//  Edge counter: runs 0..P-1 per bit. Samples are taken at edges P/2-1, P/2 and P/2+1.
//    Majority-of-3 is available the cycle after edge P/2+1.
//  FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
//   IDLE -> START on synchronised RX = 0; edge counter is cleared.
//   START: majority 1 -> IDLE (glitch, nothing delivered); at edge P-1 -> DATA.
//   DATA: shifts DATA_WIDTH bits LSB first. At the last bit's edge P-1 -> PARITY if PAR_EN, else -> STOP.
//   PARITY: compares the sampled bit against XOR(data)^Par_Type. At edge P-1 -> STOP.
//   STOP: one or two bits.
//     After the majority of the LAST stop bit, the frame completes and leaves STOP.
//     Goes -> IDLE if that bit is 1, -> WAIT_IDLE if it is 0.
//     This early exit gives half a bit of resync margin.
//   WAIT_IDLE -> IDLE when synchronised RX = 1. Stops a held-low line from retriggering.
//  Frame completion: in the cycle after completion, PDATA and the flags load and Data_Valid = 1.
//   Frm_Err = any stop bit 0.
//   Brk = Frm_Err & all data bits 0 & (parity bit 0 if enabled).
//   Errored frames are still delivered, with their flags set.
//  Handshake: Valid & Ready in a cycle consumes the word. Valid drops next cycle unless a new frame loads that same cycle.
//   If a load and a consume happen in the same cycle, the new word loads, Valid stays 1 and Ovr_Err = 0.
//   If a load happens while Valid & !Ready, the new word overwrites the old one and Ovr_Err = 1.
//   All flags describe the currently held word. They clear when it is consumed.
//  Reset mid-frame: the frame is abandoned immediately and all outputs return to 0.
//  Busy = 1 in START/DATA/PARITY/STOP.
// TESTING
//  1. P=16, 8N1, byte 0xA5, Ready=1 -> PDATA=0xA5, Valid high 1 cycle, all flags 0.
//  2. P=8, PAR_EN=1, odd parity, 0x3C with wrong parity bit -> PDATA=0x3C, Par_Err=1.
//  3. Start pulse low for only P/4 clocks -> no Valid, FSM back to IDLE, Busy drops.
//  4. Line held low for 2 frame times -> one word 0x00 with Frm_Err=1, Brk=1. No further word until the line goes high.
//  5. Two frames 0x11, 0x22 with Ready=0 -> PDATA=0x22, Ovr_Err=1. Assert Ready -> Valid and Ovr_Err clear.
//  6. DATA_WIDTH=9, STOP2=1, P=32, second stop bit 0 -> Frm_Err=1. Assert RST mid-frame -> all outputs 0.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param
//   Parametrised UART receiver with 5..9 data bits, optional even/odd parity
//   and one or two stop bits. Every bit is sampled three times around mid-bit
//   and resolved by majority vote. Received words are presented through a
//   valid/ready holding register, together with per-word error flags.
//
// Ports
//   UartRxP_CLK         in   system clock, rising edge
//   UartRxP_RST         in   asynchronous, active-high reset
//   UartRxP_RX_IN       in   serial line, idle high, asynchronous to CLK
//   UartRxP_prescale    in   clocks per bit (8/16/32, anything else -> 8)
//   UartRxP_PAR_EN      in   parity bit present after data
//   UartRxP_Par_Type    in   0 = even, 1 = odd
//   UartRxP_STOP2       in   two stop bits expected
//   UartRxP_Data_Ready  in   consumer accepts PDATA when Valid & Ready
//   UartRxP_PDATA       out  received word
//   UartRxP_Data_Valid  out  held word valid until consumed
//   UartRxP_Par_Err     out  parity mismatch for held word
//   UartRxP_Frm_Err     out  a stop bit sampled 0 for held word
//   UartRxP_Brk         out  data, parity and stop bits all 0
//   UartRxP_Ovr_Err     out  held word overwrote an unconsumed word
//   UartRxP_Busy        out  receiving a frame (START/DATA/PARITY/STOP)
module uart_rx_param #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  UartRxP_CLK,
    input  logic                  UartRxP_RST,
    input  logic                  UartRxP_RX_IN,
    input  logic [PRESCALE_W-1:0] UartRxP_prescale,
    input  logic                  UartRxP_PAR_EN,
    input  logic                  UartRxP_Par_Type,
    input  logic                  UartRxP_STOP2,
    input  logic                  UartRxP_Data_Ready,
    output logic [DATA_WIDTH-1:0] UartRxP_PDATA,
    output logic                  UartRxP_Data_Valid,
    output logic                  UartRxP_Par_Err,
    output logic                  UartRxP_Frm_Err,
    output logic                  UartRxP_Brk,
    output logic                  UartRxP_Ovr_Err,
    output logic                  UartRxP_Busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t state, state_nxt;

    logic                  rx_meta, rx_sync;
    logic [PRESCALE_W-1:0] p_lat, edge_cnt, half;
    logic                  par_en_lat, par_type_lat, stop2_lat;
    logic [3:0]            bit_cnt;
    logic [2:0]            smp;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_bit, stop_err;

    logic start_det, edge_last, maj_valid, maj, last_stop, complete;
    logic frm_new, par_new, brk_new, consume;

    // Only 16 and 32 are taken as given; every other value falls back to 8.
    function automatic logic [PRESCALE_W-1:0] legal_p(input logic [PRESCALE_W-1:0] p);
        if (int'(p) == 16 || int'(p) == 32)
            return p;
        else
            return PRESCALE_W'(8);
    endfunction

    always_comb begin
        start_det = (state == IDLE) && !rx_sync;
        half      = p_lat >> 1;
        edge_last = (edge_cnt == p_lat - PRESCALE_W'(1));
        // Samples land at half-1, half, half+1; the vote is usable one cycle later.
        maj_valid = (edge_cnt == half + PRESCALE_W'(2));
        maj       = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
        last_stop = (bit_cnt == (stop2_lat ? 4'd1 : 4'd0));
        complete  = (state == STOP) && maj_valid && last_stop;
        frm_new   = stop_err | ~maj;
        par_new   = par_en_lat & (par_bit ^ (^shift) ^ par_type_lat);
        brk_new   = frm_new & ~(|shift) & ~(par_en_lat & par_bit);
        consume   = UartRxP_Data_Valid & UartRxP_Data_Ready;
        UartRxP_Busy = state inside {START, DATA, PARITY, STOP};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!rx_sync) state_nxt = START;
            START: begin
                if (maj_valid && maj)
                    state_nxt = IDLE;
                else if (edge_last)
                    state_nxt = DATA;
            end
            DATA: begin
                if (edge_last && bit_cnt == 4'(DATA_WIDTH - 1))
                    state_nxt = par_en_lat ? PARITY : STOP;
            end
            PARITY:    if (edge_last) state_nxt = STOP;
            // Leave at the vote of the last stop bit, not at its end, so the
            // next start edge is caught with half a bit of margin.
            STOP:      if (complete) state_nxt = maj ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_sync) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge UartRxP_CLK or posedge UartRxP_RST) begin
        if (UartRxP_RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge UartRxP_CLK or posedge UartRxP_RST) begin
        if (UartRxP_RST) begin
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            p_lat        <= PRESCALE_W'(8);
            par_en_lat   <= 1'b0;
            par_type_lat <= 1'b0;
            stop2_lat    <= 1'b0;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            smp          <= '1;
            shift        <= '0;
            par_bit      <= 1'b0;
            stop_err     <= 1'b0;
        end else begin
            rx_meta <= UartRxP_RX_IN;
            rx_sync <= rx_meta;

            if (start_det) begin
                p_lat        <= legal_p(UartRxP_prescale);
                par_en_lat   <= UartRxP_PAR_EN;
                par_type_lat <= UartRxP_Par_Type;
                stop2_lat    <= UartRxP_STOP2;
                par_bit      <= 1'b0;
                stop_err     <= 1'b0;
            end

            if (state == IDLE || state == WAIT_IDLE || edge_last)
                edge_cnt <= '0;
            else
                edge_cnt <= edge_cnt + PRESCALE_W'(1);

            if (state != state_nxt)
                bit_cnt <= '0;
            else if (edge_last && (state == DATA || state == STOP))
                bit_cnt <= bit_cnt + 4'd1;

            if (edge_cnt == half - PRESCALE_W'(1)) smp[0] <= rx_sync;
            if (edge_cnt == half)                  smp[1] <= rx_sync;
            if (edge_cnt == half + PRESCALE_W'(1)) smp[2] <= rx_sync;

            // LSB arrives first, so shift right and insert at the top.
            if (state == DATA && maj_valid)
                shift <= {maj, shift[DATA_WIDTH-1:1]};
            if (state == PARITY && maj_valid)
                par_bit <= maj;
            if (state == STOP && maj_valid && !maj)
                stop_err <= 1'b1;
        end
    end

    always_ff @(posedge UartRxP_CLK or posedge UartRxP_RST) begin
        if (UartRxP_RST) begin
            UartRxP_PDATA      <= '0;
            UartRxP_Data_Valid <= 1'b0;
            UartRxP_Par_Err    <= 1'b0;
            UartRxP_Frm_Err    <= 1'b0;
            UartRxP_Brk        <= 1'b0;
            UartRxP_Ovr_Err    <= 1'b0;
        end else if (complete) begin
            // A load wins over a same-cycle consume; only an unconsumed
            // word being replaced counts as overrun.
            UartRxP_PDATA      <= shift;
            UartRxP_Data_Valid <= 1'b1;
            UartRxP_Par_Err    <= par_new;
            UartRxP_Frm_Err    <= frm_new;
            UartRxP_Brk        <= brk_new;
            UartRxP_Ovr_Err    <= UartRxP_Data_Valid & ~UartRxP_Data_Ready;
        end else if (consume) begin
            UartRxP_Data_Valid <= 1'b0;
            UartRxP_Par_Err    <= 1'b0;
            UartRxP_Frm_Err    <= 1'b0;
            UartRxP_Brk        <= 1'b0;
            UartRxP_Ovr_Err    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: one 8-bit and one 9-bit instance share clock,
// reset and configuration; each has its own line and Ready. Expected words
// are queued as frames are sent and compared when the DUT hands them over.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx8 = 1'b1, rx9 = 1'b1;
    logic [5:0] prescale = 6'd16;
    logic       par_en = 1'b0, par_type = 1'b0, stop2 = 1'b0;
    logic       ready8 = 1'b1, ready9 = 1'b1;

    logic [7:0] pdata8;
    logic       valid8, par8, frm8, brk8, ovr8, busy8;
    logic [8:0] pdata9;
    logic       valid9, par9, frm9, brk9, ovr9, busy9;

    int checks = 0;
    int errors = 0;

    // {pdata, par_err, frm_err, brk, ovr_err}
    logic [11:0] q8[$];
    logic [12:0] q9[$];

    always #5 clk = ~clk;

    uart_rx_param #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut8 (
        .UartRxP_CLK(clk), .UartRxP_RST(rst), .UartRxP_RX_IN(rx8),
        .UartRxP_prescale(prescale), .UartRxP_PAR_EN(par_en),
        .UartRxP_Par_Type(par_type), .UartRxP_STOP2(stop2),
        .UartRxP_Data_Ready(ready8), .UartRxP_PDATA(pdata8),
        .UartRxP_Data_Valid(valid8), .UartRxP_Par_Err(par8),
        .UartRxP_Frm_Err(frm8), .UartRxP_Brk(brk8),
        .UartRxP_Ovr_Err(ovr8), .UartRxP_Busy(busy8)
    );

    uart_rx_param #(.DATA_WIDTH(9), .PRESCALE_W(6)) dut9 (
        .UartRxP_CLK(clk), .UartRxP_RST(rst), .UartRxP_RX_IN(rx9),
        .UartRxP_prescale(prescale), .UartRxP_PAR_EN(par_en),
        .UartRxP_Par_Type(par_type), .UartRxP_STOP2(stop2),
        .UartRxP_Data_Ready(ready9), .UartRxP_PDATA(pdata9),
        .UartRxP_Data_Valid(valid9), .UartRxP_Par_Err(par9),
        .UartRxP_Frm_Err(frm9), .UartRxP_Brk(brk9),
        .UartRxP_Ovr_Err(ovr9), .UartRxP_Busy(busy9)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame: start, nb data bits LSB first, optional parity, stops.
    task automatic send(input bit lane9, input logic [8:0] data, input int nb,
                        input int p, input bit pen, input bit ptype, input bit pbit,
                        input bit two, input bit s1, input bit s2);
        logic [15:0] v;
        int n;
        prescale = 6'(p);
        par_en   = pen;
        par_type = ptype;
        stop2    = two;
        v = '1;
        v[0] = 1'b0;
        for (int i = 0; i < nb; i++) v[1+i] = data[i];
        n = 1 + nb;
        if (pen) begin v[n] = pbit; n++; end
        v[n] = s1; n++;
        if (two) begin v[n] = s2; n++; end
        for (int i = 0; i < n; i++) begin
            if (lane9) rx9 = v[i]; else rx8 = v[i];
            tick(p);
        end
        rx8 = 1'b1;
        rx9 = 1'b1;
        tick(4);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst && valid8 && ready8) begin
                    if (q8.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dut8 unexpected word: got %h expected none",
                                 {pdata8, par8, frm8, brk8, ovr8});
                    end else
                        chk("dut8 word", 32'({pdata8, par8, frm8, brk8, ovr8}), 32'(q8.pop_front()));
                end
                if (!rst && valid9 && ready9) begin
                    if (q9.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dut9 unexpected word: got %h expected none",
                                 {pdata9, par9, frm9, brk9, ovr9});
                    end else
                        chk("dut9 word", 32'({pdata9, par9, frm9, brk9, ovr9}), 32'(q9.pop_front()));
                end
            end
        join_none

        // Reset state
        tick(3);
        chk("reset dut8 outputs", 32'({pdata8, valid8, par8, frm8, brk8, ovr8, busy8}), 32'd0);
        chk("reset dut9 outputs", 32'({pdata9, valid9, par9, frm9, brk9, ovr9, busy9}), 32'd0);
        rst = 1'b0;
        tick(3);

        // 1: 8N1 at P=16, 0xA5 with Ready high
        q8.push_back({8'hA5, 4'b0000});
        send(1'b0, 9'h0A5, 8, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t1 valid dropped", 32'(valid8), 32'd0);
        chk("t1 idle", 32'(busy8), 32'd0);

        // 2: P=8, odd parity, 0x3C needs parity 1; send 0 instead
        q8.push_back({8'h3C, 4'b1000});
        send(1'b0, 9'h03C, 8, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

        // 3: start glitch of P/4 clocks
        prescale = 6'd16;
        par_en   = 1'b0;
        rx8 = 1'b0;
        tick(4);
        rx8 = 1'b1;
        chk("t3 busy during glitch", 32'(busy8), 32'd1);
        tick(30);
        chk("t3 busy after glitch", 32'(busy8), 32'd0);
        chk("t3 no valid", 32'(valid8), 32'd0);

        // 4: line low for two frame times -> one break word
        q8.push_back({8'h00, 4'b0110});
        rx8 = 1'b0;
        tick(320);
        chk("t4 waiting, not busy", 32'(busy8), 32'd0);
        chk("t4 no second word", 32'(valid8), 32'd0);
        rx8 = 1'b1;
        tick(20);
        chk("t4 idle after release", 32'(busy8), 32'd0);

        // 5: overrun with Ready low
        ready8 = 1'b0;
        q8.push_back({8'h22, 4'b0001});
        send(1'b0, 9'h011, 8, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t5 first word held", 32'({valid8, pdata8, ovr8}), 32'({1'b1, 8'h11, 1'b0}));
        send(1'b0, 9'h022, 8, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t5 second word held", 32'(valid8), 32'd1);
        ready8 = 1'b1;
        tick(1);
        chk("t5 valid/ovr cleared", 32'({valid8, ovr8}), 32'd0);

        // 6: 9 data bits, two stops at P=32, second stop 0
        q9.push_back({9'h1A5, 4'b0100});
        send(1'b1, 9'h1A5, 9, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(4);
        ready9 = 1'b0;
        send(1'b1, 9'h0F3, 9, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("t6 held word", 32'({valid9, pdata9, frm9}), 32'({1'b1, 9'h0F3, 1'b0}));
        rx9 = 1'b0;
        tick(60);
        chk("t6 busy mid-frame", 32'(busy9), 32'd1);
        rst = 1'b1;
        tick(1);
        chk("t6 reset mid-frame", 32'({pdata9, valid9, par9, frm9, brk9, ovr9, busy9}), 32'd0);
        rx9 = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(10);

        chk("dut8 queue drained", 32'(q8.size()), 32'd0);
        chk("dut9 queue drained", 32'(q9.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
